// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_add_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select encoding for op_sub.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit_add_cell.sv
// One-bit combinational full adder; the only arithmetic in the controller.
module bit_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    // Sum and majority carry.
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: time-shares one full-adder cell over
// WIDTH-bit operands, LSB first, one bit per clock.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready and out_valid depend on the state register only, so neither
// in_valid nor out_ready has a combinational path to any output. The producer
// holds operands only in the handshake cycle; the result stays on sum/cout/ovf
// with out_valid high until the consumer raises out_ready.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    // Partial sum bits 0..WIDTH-2; the MSB comes straight from the cell on
    // the last cycle, so the staging register is one bit narrower.
    logic [WIDTH-2:0]  sum_sr;
    logic [WIDTH-1:0]  sum_next;
    logic              carry;
    logic              cell_s;
    logic              cell_c;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              last_bit;

    bit_add_cell u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (cell_s),
        .c   (cell_c)
    );

    assign sum_next = {cell_s, sum_sr};
    assign last_bit = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand load, per-bit shifting and result capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert B and seed the carry.
                        a_sr   <= a;
                        b_sr   <= (op_sub == OP_SUB) ? ~b : b;
                        carry  <= (op_sub == OP_SUB);
                        sum_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next[WIDTH-1:1];
                    carry  <= cell_c;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here.
                        sum_q  <= sum_next;
                        cout_q <= cell_c;
                        ovf_q  <= carry ^ cell_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, cout, ovf, busy;
    logic [7:0] sum;
    state_t     dbg_state;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- WIDTH=2 instance ----------------
    logic       w2_in_valid = 1'b0, w2_op_sub = 1'b0, w2_out_ready = 1'b0;
    logic [1:0] w2_a = '0, w2_b = '0;
    logic       w2_in_ready, w2_out_valid, w2_cout, w2_ovf, w2_busy;
    logic [1:0] w2_sum;
    state_t     w2_dbg_state;

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .op_sub(w2_op_sub), .a(w2_a), .b(w2_b), .out_valid(w2_out_valid),
        .out_ready(w2_out_ready), .sum(w2_sum), .cout(w2_cout), .ovf(w2_ovf),
        .busy(w2_busy), .dbg_state(w2_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: wide add, overflow from operand/result signs.
    function automatic logic [9:0] ref8(input logic sub, input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] bb;
        logic [8:0] full;
        logic       o;
        bb   = sub ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {8'd0, sub};
        o    = (av[7] == bb[7]) && (full[7] != av[7]);
        return {full[8], o, full[7:0]};
    endfunction

    function automatic logic [3:0] ref2(input logic sub, input logic [1:0] av, input logic [1:0] bv);
        logic [1:0] bb;
        logic [2:0] full;
        logic       o;
        bb   = sub ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {2'd0, sub};
        o    = (av[1] == bb[1]) && (full[1] != av[1]);
        return {full[2], o, full[1:0]};
    endfunction

    // ---------------- scoreboards ----------------
    logic [9:0] exp_q[$];
    logic [3:0] exp2_q[$];
    logic [9:0] e8;
    logic [3:0] e2;
    int pops8 = 0, pops2 = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("w8_unexpected_result", 32'({cout, ovf, sum}), 32'h3ff_ffff);
            end else begin
                e8 = exp_q.pop_front();
                pops8++;
                chk("w8_result", 32'({cout, ovf, sum}), 32'(e8));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w2_out_valid && w2_out_ready) begin
            if (exp2_q.size() == 0) begin
                chk("w2_unexpected_result", 32'({w2_cout, w2_ovf, w2_sum}), 32'h3ff_ffff);
            end else begin
                e2 = exp2_q.pop_front();
                pops2++;
                chk("w2_result", 32'({w2_cout, w2_ovf, w2_sum}), 32'(e2));
            end
        end
    end

    // Issue-interval tracking (accept edges are seen a half cycle early).
    bit track = 1'b0;
    int last8 = -1, last2 = -1, min8 = 1000000, min2 = 1000000;

    always @(negedge clk) begin
        if (track && rst_n && in_valid && in_ready) begin
            if (last8 >= 0 && (cyc - last8) < min8) min8 = cyc - last8;
            last8 = cyc;
        end
        if (track && rst_n && w2_in_valid && w2_in_ready) begin
            if (last2 >= 0 && (cyc - last2) < min2) min2 = cyc - last2;
            last2 = cyc;
        end
    end

    // Random back-pressure for the soak phase.
    bit rnd_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            w2_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send8(input logic sub, input logic [7:0] av, input logic [7:0] bv, input logic [9:0] exp);
        int waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            chk("w8_in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op_sub = sub; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
    endtask

    task automatic send2(input logic sub, input logic [1:0] av, input logic [1:0] bv, input logic [3:0] exp);
        int waitc = 0;
        @(negedge clk);
        while (!w2_in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!w2_in_ready) begin
            chk("w2_in_ready_timeout", 32'(w2_in_ready), 32'd1);
            return;
        end
        w2_op_sub = sub; w2_a = av; w2_b = bv; w2_in_valid = 1'b1;
        @(posedge clk);
        exp2_q.push_back(exp);
        #1;
        w2_in_valid = 1'b0;
        w2_a = 2'($urandom); w2_b = 2'($urandom); w2_op_sub = 1'($urandom);
    endtask

    // Called right after send8: counts edges from accept to out_valid.
    task automatic wait_valid8();
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("w8_latency", 32'(lat), 32'd8);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{OP_ADD, 8'h3C, 8'h25, 8'h61, 1'b0, 1'b0};
        vecs[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{OP_ADD, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{OP_SUB, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{OP_SUB, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{OP_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'({cout, ovf, sum}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        out_ready = 1'b1;
        w2_out_ready = 1'b1;

        // Table: out_ready held high.
        for (int i = 0; i < 10; i++) begin
            send8(vecs[i].sub, vecs[i].a, vecs[i].b, {vecs[i].cout, vecs[i].ovf, vecs[i].sum});
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            wait_valid8();
            @(posedge clk);
            #1;
            chk("ack_in_ready", 32'(in_ready), 32'd1);
        end

        // Back-pressure: result held, input pulses ignored.
        out_ready = 1'b0;
        e8 = ref8(OP_ADD, 8'h12, 8'h34);
        send8(OP_ADD, 8'h12, 8'h34, e8);
        wait_valid8();
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'({cout, ovf, sum}), 32'(e8));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_no_extra_run", 32'(busy), 32'd0);
        chk("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of RUN, at bit 4.
        send8(OP_ADD, 8'h3C, 8'h25, ref8(OP_ADD, 8'h3C, 8'h25));
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'({cout, ovf, sum}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_no_output", 32'(out_valid), 32'd0);
        send8(OP_SUB, 8'h80, 8'h01, ref8(OP_SUB, 8'h80, 8'h01));
        wait_valid8();
        @(posedge clk);
        #1;

        // Random soak on both widths with random back-pressure.
        pops8 = 0;
        pops2 = 0;
        track = 1'b1;
        rnd_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic       s8;
                    logic [7:0] ra, rb;
                    s8 = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
                    send8(s8, ra, rb, ref8(s8, ra, rb));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic       s2;
                    logic [1:0] qa, qb;
                    s2 = 1'($urandom); qa = 2'($urandom); qb = 2'($urandom);
                    send2(s2, qa, qb, ref2(s2, qa, qb));
                end
            end
        join
        for (int t = 0; t < 400 && (exp_q.size() != 0 || exp2_q.size() != 0); t++) begin
            @(posedge clk);
        end
        #1;
        chk("w8_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("w2_queue_empty", 32'(exp2_q.size()), 32'd0);
        chk("w8_result_count", 32'(pops8), 32'd1000);
        chk("w2_result_count", 32'(pops2), 32'd1000);
        chk("w8_min_interval_ge_10", 32'(min8 >= 10), 32'd1);
        chk("w2_min_interval_ge_4", 32'(min2 >= 4), 32'd1);
        chk("w8_min_interval_seen", 32'(min8 < 1000000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #3000000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single one-bit full-adder cell over WIDTH-bit operands, LSB first, one bit per clock. It latches an operand pair over a valid/ready handshake, runs WIDTH adder cycles with a registered carry, and presents sum, carry and signed-overflow over a second valid/ready handshake. It is the block that time-shares one full-adder datapath in place of a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  controller can accept operands.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with operands.
- a  input  WIDTH  operand A; sampled on input handshake.
- b  input  WIDTH  operand B; sampled on input handshake.
- out_valid  output  1  result available; held until accepted.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: load a into shift register A, (op_sub ? ~b : b) into shift register B, carry register = op_sub, clear sum register and bit counter; go RUN.
- RUN: each cycle feed A[0], B[0], carry to the full-adder cell; shift sum bit into sum register MSB, shift A and B right by one, carry <= cell carry, counter++. When counter == WIDTH-1 on that cycle (last bit), also capture carry-into-MSB for ovf; go DONE.
- DONE: out_valid=1; sum/cout/ovf stable. On out_valid&&out_ready go IDLE. Inputs ignored (in_ready=0).
- in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready to any output.
- Inputs arriving while not in IDLE are not sampled; a, b, op_sub may change freely outside the handshake cycle.
- Arithmetic: sum = (a + (op_sub ? ~b : b) + op_sub) mod 2^WIDTH; cout = bit WIDTH of that sum; ovf = c_in(MSB) ^ cout.

## Timing
- Reset (rst_n low, any state, any time): state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, counter=0, carry=0. Operation in progress is discarded; no partial result is emitted.
- Input handshake at edge T0 -> RUN from T0; WIDTH RUN cycles; out_valid high in the cycle after edge T0+WIDTH. Latency = WIDTH cycles from accept to out_valid.
- out_ready already high when out_valid rises: result accepted in that cycle, IDLE next cycle, in_ready high. Minimum issue interval = WIDTH+2 cycles.
- out_ready held low: DONE persists indefinitely, outputs unchanged.
- sum, cout, ovf retain last result after return to IDLE until the next result overwrites them in DONE entry; they are valid only when out_valid=1.
- Counter wraps never; it is cleared on accept and counts 0..WIDTH-1.

## Structure
- Package serial_add_pkg: state typedef (IDLE, RUN, DONE), op constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module bit_add_cell: combinational one-bit full adder (a, b, cin -> s, c), single instance.
- Top: FSM, counter ($clog2(WIDTH) bits), A/B/sum shift registers, carry and ovf registers.

## Test plan
- WIDTH=8, add a=8'h3C, b=8'h25, out_ready=1 -> out_valid 8 cycles after accept, sum=8'h61, cout=0, ovf=0.
- Add a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0; add a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Subtract a=8'h05, b=8'h07 -> sum=8'hFE, cout=0 (borrow), ovf=0; subtract a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Back-pressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; on out_ready high -> IDLE next cycle.
- Reset mid-RUN (rst_n low at bit 4) -> all outputs at reset values immediately; next operand pair after release produces correct result.
- Random a, b, op_sub, random out_ready, 1000 ops for WIDTH=8 and WIDTH=2 -> every result matches reference arithmetic; issue interval ≥ WIDTH+2.
